hms_timer: RTL and testbench
============================

Name: hms_timer

Overview:
- Parametrised successor of the team's countdown timer.
- Holds an hr:min:sec:ms value and counts it down (timer mode) or up (stopwatch mode).
- Uses a programmable clock prescaler, clamps preset values on load, and exits through an explicit state machine with a one-cycle expiry pulse.
- Sits between the preset/button logic and the display formatter; out_time feeds the display path unchanged.

Parameters:
- TICK_DIV, 1: clk cycles per millisecond tick; 1 means every clk edge is one ms tick. Legal range ≥1.
- HR_W, 5: width of the hour field.
- HR_MAX, 23: largest hour value; must fit in HR_W bits.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- load  in  1: level; copies the clamped presets into the counter.
- run  in  1: level; 1 = count, 0 = pause.
- count_up  in  1: mode select; 1 = stopwatch (count up), 0 = countdown. Sampled only when leaving IDLE.
- ms_i  in  10: preset milliseconds.
- sec_i  in  6: preset seconds.
- min_i  in  6: preset minutes.
- hr_i  in  HR_W: preset hours.
- lap  in  1: lap capture strobe (used only with LAP_EN).
- out_time  out  HR_W+22: {hr,min,sec,ms}, driven directly from the field registers.
- lap_time  out  HR_W+22: captured lap value.
- running  out  1: high while state==RUN.
- expired  out  1: one-cycle pulse on reaching the terminal value.

Behaviour:
- Reset (reset=0, async):
  - All fields, prescaler, mode, lap_time and expired go to 0.
  - State goes to IDLE.
  - Outputs stay 0 until the first load.
- States: IDLE, RUN, PAUSE, DONE. Registered outputs update on the edge that changes the fields or state.
- load=1 (any state, highest priority after reset):
  - Fields take clamped presets: ms>999→999, sec>59→59, min>59→59, hr>HR_MAX→HR_MAX.
  - State→IDLE, prescaler→0, expired→0.
  - run is ignored in a load cycle.
- IDLE:
  - On run=1: latch count_up into the mode register.
  - Down mode with value==0: stay in IDLE, no expired pulse.
  - Otherwise: go to RUN, prescaler starts from 0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. When it is at TICK_DIV-1, apply one ms step and wrap the prescaler to 0.
  - First step lands on the TICK_DIV-th edge after entering RUN.
  - run=0: go to PAUSE; the prescaler is held, with no step that cycle.
- Down step:
  - ms decrements.
  - ms 0 → 999 with a borrow to sec; sec 0 → 59 with a borrow to min; min 0 → 59 with a borrow to hr.
  - If the result is all-zero: go to DONE and assert expired in the same cycle.
- Up step:
  - ms increments.
  - ms 999 → 0 with a carry to sec; sec 59 → 0 with a carry to min; min 59 → 0 with a carry to hr.
  - If the result equals HR_MAX:59:59:999: hold that value, go to DONE, assert expired.
  - There is no wrap past HR_MAX.
- PAUSE:
  - Fields and prescaler are held.
  - run=1: back to RUN; the prescaler resumes from its held value.
  - The mode register is not re-sampled.
- DONE:
  - Value is held.
  - run is ignored; only load or reset exits.
  - expired returns to 0 on the next cycle.
- count_up changes during RUN/PAUSE/DONE are ignored.
- Fields never leave their legal range. All arithmetic is at field width, with explicit wrap constants.

Optional Feature:
- Macro: HMS_TIMER_LAP_EN.
- Defined:
  - lap=1 in RUN or PAUSE captures out_time into lap_time on that edge. If a step occurs on the same edge, the pre-step value is captured.
  - lap in IDLE or DONE is ignored.
  - load clears lap_time.
- Not defined: lap is unused and lap_time is tied to 0.
- Ports exist in both builds.

Decomposition:
- Package timer_pkg holds:
  - MS_W=10, SEC_W=6, MIN_W=6.
  - MS_MAX=999, SEC_MAX=59, MIN_MAX=59.
  - State enum typedef (IDLE, RUN, PAUSE, DONE).
- One combinational sub-module, hms_step: takes the current fields and direction; returns the next fields plus at_zero and at_max flags.
- Prescaler and FSM stay in hms_timer.

Test Plan:
- Down, TICK_DIV=1: load 0:00:01:002, run=1 → on successive edges 0:00:01:001, :000, 0:00:00:999; expired never high during this window.
- Down expiry: load 0:00:00:003, run=1 → 3 steps to 0, expired high exactly one cycle, running=0, state DONE; further run toggles leave 0.
- Up saturate, HR_MAX=23: load 23:59:59:997 with count_up=1 → 998, 999, then DONE with value held at 23:59:59:999 and one expired pulse.
- Clamp plus prescaler, TICK_DIV=4: load with hr_i=31, min_i=60, ms_i=1023 → out_time 23:59:xx:999; with run=1 the first step lands on the 4th edge.
- Pause/resume/reset mid-run, TICK_DIV=4: drop run after 2 prescaler counts → value held for 10 cycles; on resume the step arrives after 2 more edges. Assert reset=0 mid-RUN → out_time=0 immediately (async), IDLE.
- LAP_EN build: lap pulse at 0:00:05:500 during RUN → lap_time=0:00:05:500 while out_time keeps counting. Non-LAP build: lap_time stays 0.

Source files
------------

// File: rtl/hms_timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared field widths, wrap constants and the state encoding for hms_timer
// and its step logic.
// Ports: none (package).
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;

    localparam int MS_MAX  = 999;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hms_timer_if.sv
// ---------------------------------------------------------------------------
// hms_timer_if
// Bundles the control, preset and result signals of hms_timer.
// Ports (via modports):
//   master : drives load, run, count_up, lap, ms_i, sec_i, min_i, hr_i;
//            observes out_time, lap_time, running, expired.
//   slave  : the timer side, opposite directions.
// ---------------------------------------------------------------------------
interface hms_timer_if
    import timer_pkg::*;
#(
    parameter int HR_W = 5
);

    logic                 load;
    logic                 run;
    logic                 count_up;
    logic                 lap;
    logic [MS_W-1:0]      ms_i;
    logic [SEC_W-1:0]     sec_i;
    logic [MIN_W-1:0]     min_i;
    logic [HR_W-1:0]      hr_i;
    logic [HR_W+21:0]     out_time;
    logic [HR_W+21:0]     lap_time;
    logic                 running;
    logic                 expired;

    modport master (
        output load, run, count_up, lap, ms_i, sec_i, min_i, hr_i,
        input  out_time, lap_time, running, expired
    );

    modport slave (
        input  load, run, count_up, lap, ms_i, sec_i, min_i, hr_i,
        output out_time, lap_time, running, expired
    );

endinterface

// File: rtl/hms_timer_step.sv
// ---------------------------------------------------------------------------
// hms_step
// Combinational one-millisecond step of an hr:min:sec:ms value, either up or
// down, with borrow/carry through the fields.
// Ports:
//   up                      : 1 = increment, 0 = decrement
//   ms/sec/min/hr           : current field values
//   ms_next..hr_next        : stepped field values
//   at_zero                 : stepped value is 0:00:00:000
//   at_max                  : stepped value is HR_MAX:59:59:999
// ---------------------------------------------------------------------------
module hms_step
    import timer_pkg::*;
#(
    parameter int HR_W   = 5,
    parameter int HR_MAX = 23
) (
    input  logic             up,
    input  logic [MS_W-1:0]  ms,
    input  logic [SEC_W-1:0] sec,
    input  logic [MIN_W-1:0] min,
    input  logic [HR_W-1:0]  hr,
    output logic [MS_W-1:0]  ms_next,
    output logic [SEC_W-1:0] sec_next,
    output logic [MIN_W-1:0] min_next,
    output logic [HR_W-1:0]  hr_next,
    output logic             at_zero,
    output logic             at_max
);

    logic cur_zero;
    logic cur_max;

    // A step from a terminal value holds it, so the value can never leave
    // its legal range even if the caller steps once too often.
    always_comb begin
        cur_zero = (ms == '0) && (sec == '0) && (min == '0) && (hr == '0);
        cur_max  = (ms == MS_W'(MS_MAX)) && (sec == SEC_W'(SEC_MAX)) &&
                   (min == MIN_W'(MIN_MAX)) && (hr == HR_W'(HR_MAX));
        ms_next  = ms;
        sec_next = sec;
        min_next = min;
        hr_next  = hr;
        if (up) begin
            if (!cur_max) begin
                if (ms == MS_W'(MS_MAX)) begin
                    ms_next = '0;
                    if (sec == SEC_W'(SEC_MAX)) begin
                        sec_next = '0;
                        if (min == MIN_W'(MIN_MAX)) begin
                            min_next = '0;
                            hr_next  = hr + HR_W'(1);
                        end else begin
                            min_next = min + MIN_W'(1);
                        end
                    end else begin
                        sec_next = sec + SEC_W'(1);
                    end
                end else begin
                    ms_next = ms + MS_W'(1);
                end
            end
        end else begin
            if (!cur_zero) begin
                if (ms == '0) begin
                    ms_next = MS_W'(MS_MAX);
                    if (sec == '0) begin
                        sec_next = SEC_W'(SEC_MAX);
                        if (min == '0) begin
                            min_next = MIN_W'(MIN_MAX);
                            hr_next  = hr - HR_W'(1);
                        end else begin
                            min_next = min - MIN_W'(1);
                        end
                    end else begin
                        sec_next = sec - SEC_W'(1);
                    end
                end else begin
                    ms_next = ms - MS_W'(1);
                end
            end
        end
        at_zero = (ms_next == '0) && (sec_next == '0) &&
                  (min_next == '0) && (hr_next == '0);
        at_max  = (ms_next == MS_W'(MS_MAX)) && (sec_next == SEC_W'(SEC_MAX)) &&
                  (min_next == MIN_W'(MIN_MAX)) && (hr_next == HR_W'(HR_MAX));
    end

endmodule

// File: rtl/hms_timer.sv
// ---------------------------------------------------------------------------
// hms_timer
// hr:min:sec:ms countdown timer / stopwatch with a clock prescaler, clamped
// presets and a one-cycle expiry pulse.
// Optional lap capture is enabled by defining HMS_TIMER_LAP_EN.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : hms_timer_if.slave (load/run/count_up/lap, presets,
//           out_time/lap_time/running/expired)
// ---------------------------------------------------------------------------
module hms_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int HR_W     = 5,
    parameter int HR_MAX   = 23
) (
    input  logic        clk,
    input  logic        reset,
    hms_timer_if.slave  bus
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t             state;
    logic               mode_up;
    logic [PRE_W-1:0]   pre;
    logic [MS_W-1:0]    ms_q;
    logic [SEC_W-1:0]   sec_q;
    logic [MIN_W-1:0]   min_q;
    logic [HR_W-1:0]    hr_q;
    logic               expired_q;
    logic [HR_W+21:0]   lap_q;

    logic [MS_W-1:0]    ms_n;
    logic [SEC_W-1:0]   sec_n;
    logic [MIN_W-1:0]   min_n;
    logic [HR_W-1:0]    hr_n;
    logic               at_zero;
    logic               at_max;
    logic               is_zero;
    logic               tick;

    hms_step #(.HR_W(HR_W), .HR_MAX(HR_MAX)) u_step (
        .up       (mode_up),
        .ms       (ms_q),
        .sec      (sec_q),
        .min      (min_q),
        .hr       (hr_q),
        .ms_next  (ms_n),
        .sec_next (sec_n),
        .min_next (min_n),
        .hr_next  (hr_n),
        .at_zero  (at_zero),
        .at_max   (at_max)
    );

    assign is_zero = (ms_q == '0) && (sec_q == '0) && (min_q == '0) && (hr_q == '0);
    assign tick    = (pre == PRE_W'(TICK_DIV - 1));

    // Load has priority over every state; expired is a pulse, so it is
    // cleared by default and only raised on the terminating step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_up   <= 1'b0;
            pre       <= '0;
            ms_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hr_q      <= '0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (bus.load) begin
                ms_q  <= (bus.ms_i  > MS_W'(MS_MAX))   ? MS_W'(MS_MAX)   : bus.ms_i;
                sec_q <= (bus.sec_i > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : bus.sec_i;
                min_q <= (bus.min_i > MIN_W'(MIN_MAX)) ? MIN_W'(MIN_MAX) : bus.min_i;
                hr_q  <= (bus.hr_i  > HR_W'(HR_MAX))   ? HR_W'(HR_MAX)   : bus.hr_i;
                state <= IDLE;
                pre   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.run) begin
                            mode_up <= bus.count_up;
                            if (bus.count_up || !is_zero) begin
                                state <= RUN;
                                pre   <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (!bus.run) begin
                            state <= PAUSE;
                        end else if (tick) begin
                            pre   <= '0;
                            ms_q  <= ms_n;
                            sec_q <= sec_n;
                            min_q <= min_n;
                            hr_q  <= hr_n;
                            if (mode_up ? at_max : at_zero) begin
                                state     <= DONE;
                                expired_q <= 1'b1;
                            end
                        end else begin
                            pre <= pre + PRE_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (bus.run) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef HMS_TIMER_LAP_EN
    // Captures the value visible before any step taken on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q <= '0;
        end else if (bus.load) begin
            lap_q <= '0;
        end else if (bus.lap && (state == RUN || state == PAUSE)) begin
            lap_q <= {hr_q, min_q, sec_q, ms_q};
        end
    end
`else
    assign lap_q = '0;
`endif

    assign bus.out_time = {hr_q, min_q, sec_q, ms_q};
    assign bus.lap_time = lap_q;
    assign bus.running  = (state == RUN);
    assign bus.expired  = expired_q;

endmodule

// File: tb/tb_hms_timer.sv
// ---------------------------------------------------------------------------
// tb_hms_timer
// Directed bench for hms_timer: one instance with TICK_DIV=1 (bus_a) and one
// with TICK_DIV=4 (bus_b). Lap expectations follow HMS_TIMER_LAP_EN.
// ---------------------------------------------------------------------------
module tb_hms_timer;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    hms_timer_if #(.HR_W(5)) bus_a ();
    hms_timer_if #(.HR_W(5)) bus_b ();

    hms_timer #(.TICK_DIV(1), .HR_W(5), .HR_MAX(23)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    hms_timer #(.TICK_DIV(4), .HR_W(5), .HR_MAX(23)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [26:0] hms(input int h, input int m, input int s, input int ms);
        hms = {5'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step_clock(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic ld, input logic rn,
                                 input logic up, input logic lp, input int h,
                                 input int m, input int s, input int ms);
        if (!sel) begin
            bus_a.load = ld; bus_a.run = rn; bus_a.count_up = up; bus_a.lap = lp;
            bus_a.hr_i = 5'(h); bus_a.min_i = 6'(m); bus_a.sec_i = 6'(s); bus_a.ms_i = 10'(ms);
        end else begin
            bus_b.load = ld; bus_b.run = rn; bus_b.count_up = up; bus_b.lap = lp;
            bus_b.hr_i = 5'(h); bus_b.min_i = 6'(m); bus_b.sec_i = 6'(s); bus_b.ms_i = 10'(ms);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [26:0] lap_exp;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_clock(2);
        checkOutput("reset_out_a", 32'(bus_a.out_time), 32'(hms(0, 0, 0, 0)));
        checkOutput("reset_out_b", 32'(bus_b.out_time), 32'(hms(0, 0, 0, 0)));
        checkOutput("reset_running", 32'(bus_a.running), 32'd0);
        checkOutput("reset_expired", 32'(bus_a.expired), 32'd0);
        checkOutput("reset_lap", 32'(bus_a.lap_time), 32'd0);
        reset = 1'b1;
        step_clock(1);

        // Countdown with borrow from seconds
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 2);
        step_clock(1);
        checkOutput("down_load", 32'(bus_a.out_time), 32'(hms(0, 0, 1, 2)));
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(1);
        checkOutput("down_enter_run", 32'(bus_a.running), 32'd1);
        checkOutput("down_enter_val", 32'(bus_a.out_time), 32'(hms(0, 0, 1, 2)));
        step_clock(1);
        checkOutput("down_1001", 32'(bus_a.out_time), 32'(hms(0, 0, 1, 1)));
        checkOutput("down_exp0", 32'(bus_a.expired), 32'd0);
        step_clock(1);
        checkOutput("down_1000", 32'(bus_a.out_time), 32'(hms(0, 0, 1, 0)));
        step_clock(1);
        checkOutput("down_0999", 32'(bus_a.out_time), 32'(hms(0, 0, 0, 999)));
        checkOutput("down_exp1", 32'(bus_a.expired), 32'd0);

        // Countdown expiry
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 3);
        step_clock(1);
        checkOutput("exp_load", 32'(bus_a.out_time), 32'(hms(0, 0, 0, 3)));
        checkOutput("exp_load_idle", 32'(bus_a.running), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(3);
        checkOutput("exp_002_to_001", 32'(bus_a.out_time), 32'(hms(0, 0, 0, 1)));
        checkOutput("exp_not_yet", 32'(bus_a.expired), 32'd0);
        step_clock(1);
        checkOutput("exp_zero", 32'(bus_a.out_time), 32'(hms(0, 0, 0, 0)));
        checkOutput("exp_pulse", 32'(bus_a.expired), 32'd1);
        checkOutput("exp_running", 32'(bus_a.running), 32'd0);
        step_clock(1);
        checkOutput("exp_pulse_end", 32'(bus_a.expired), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_clock(1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(2);
        checkOutput("done_hold_val", 32'(bus_a.out_time), 32'(hms(0, 0, 0, 0)));
        checkOutput("done_hold_run", 32'(bus_a.running), 32'd0);
        checkOutput("done_hold_exp", 32'(bus_a.expired), 32'd0);

        // Stopwatch saturation at HR_MAX:59:59:999
        applyStimulus(0, 1, 0, 1, 0, 23, 59, 59, 997);
        step_clock(1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step_clock(2);
        checkOutput("up_998", 32'(bus_a.out_time), 32'(hms(23, 59, 59, 998)));
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(1);
        checkOutput("up_999", 32'(bus_a.out_time), 32'(hms(23, 59, 59, 999)));
        checkOutput("up_pulse", 32'(bus_a.expired), 32'd1);
        checkOutput("up_done", 32'(bus_a.running), 32'd0);
        step_clock(2);
        checkOutput("up_held", 32'(bus_a.out_time), 32'(hms(23, 59, 59, 999)));
        checkOutput("up_pulse_end", 32'(bus_a.expired), 32'd0);

        // Clamp and prescaler on the TICK_DIV=4 instance
        applyStimulus(1, 1, 1, 0, 0, 31, 60, 30, 1023);
        step_clock(1);
        checkOutput("clamp", 32'(bus_b.out_time), 32'(hms(23, 59, 30, 999)));
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(1);
        checkOutput("pre_enter_run", 32'(bus_b.running), 32'd1);
        step_clock(3);
        checkOutput("pre_edge3_hold", 32'(bus_b.out_time), 32'(hms(23, 59, 30, 999)));
        step_clock(1);
        checkOutput("pre_edge4_step", 32'(bus_b.out_time), 32'(hms(23, 59, 30, 998)));

        // Pause after two prescaler counts, then resume
        step_clock(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_clock(1);
        checkOutput("pause_running", 32'(bus_b.running), 32'd0);
        step_clock(10);
        checkOutput("pause_hold", 32'(bus_b.out_time), 32'(hms(23, 59, 30, 998)));
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(1);
        checkOutput("resume_running", 32'(bus_b.running), 32'd1);
        step_clock(1);
        checkOutput("resume_edge1_hold", 32'(bus_b.out_time), 32'(hms(23, 59, 30, 998)));
        step_clock(1);
        checkOutput("resume_edge2_step", 32'(bus_b.out_time), 32'(hms(23, 59, 30, 997)));

        // Asynchronous reset in the middle of a run
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_out", 32'(bus_b.out_time), 32'(hms(0, 0, 0, 0)));
        checkOutput("async_rst_run", 32'(bus_b.running), 32'd0);
        step_clock(1);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Lap capture takes the pre-step value
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 5, 502);
        step_clock(1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step_clock(3);
        checkOutput("lap_pre", 32'(bus_a.out_time), 32'(hms(0, 0, 5, 500)));
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 0);
        step_clock(1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef HMS_TIMER_LAP_EN
        lap_exp = hms(0, 0, 5, 500);
`else
        lap_exp = hms(0, 0, 0, 0);
`endif
        checkOutput("lap_capture", 32'(bus_a.lap_time), 32'(lap_exp));
        checkOutput("lap_counting", 32'(bus_a.out_time), 32'(hms(0, 0, 5, 499)));
        step_clock(1);
        checkOutput("lap_held", 32'(bus_a.lap_time), 32'(lap_exp));
        checkOutput("lap_counting2", 32'(bus_a.out_time), 32'(hms(0, 0, 5, 498)));
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 9);
        step_clock(1);
        checkOutput("lap_load_clear", 32'(bus_a.lap_time), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
